inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 115 +++++++++++
 tb/tb_inst_fetch_unit.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front end with request credit, response FIFO and redirect flush
module inst_fetch_unit #(
    parameter int          DEPTH           = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [31:0] MAX_O_W = 32'(MAX_OUTSTANDING);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [OW-1:0] pending;
    logic [OW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          gnt_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic [OW-1:0] pending_next;
    logic [31:0]   live_credit;
    logic [31:0]   redirect_target;

    // Live (non-stale) in-flight responses already own a FIFO slot, so a
    // request is only issued when every such response is guaranteed space.
    assign live_credit = 32'(pending - discard) + 32'(count);

    assign mem_req_o  = !rst_i && !redirect_i
                      && (32'(pending) < MAX_O_W)
                      && (live_credit < DEPTH_W);
    assign mem_addr_o = fetch_pc;

    assign gnt_fire     = mem_req_o && mem_gnt_i;
    assign rsp_fire     = mem_rvalid_i && (pending != '0);
    assign push         = rsp_fire && (discard == '0) && !redirect_i;
    assign pop          = inst_valid_o && inst_ready_i && !redirect_i;
    assign pending_next = pending + OW'(gnt_fire) - OW'(rsp_fire);

    assign redirect_target = redirect_pc_i & ~32'h0000_0003;

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : 32'h0;
    assign inst_addr_o  = inst_valid_o ? pc_mem[rd_ptr]   : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            pending  <= '0;
            discard  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            pending <= pending_next;
            if (redirect_i) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                discard  <= pending_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (gnt_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_fire) begin
                    if (discard != '0) begin
                        discard <= discard - OW'(1);
                    end else begin
                        resp_pc <= resp_pc + 32'd4;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i = 1'b0;

    inst_fetch_unit #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o),
        .inst_o(inst_o),
        .inst_addr_o(inst_addr_o),
        .inst_ready_i(inst_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t       mq[$];
    int          cyc = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;

    logic        o_req, o_gnt, o_rvalid, o_valid, o_pop;
    logic [31:0] o_addr, o_inst, o_iaddr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // One clock of the memory model; records what the fetch unit showed mid-cycle.
    task automatic step();
        resp_t r;
        mem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = memf(mq[0].addr);
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        #2;
        o_req    = mem_req_o;
        o_addr   = mem_addr_o;
        o_valid  = inst_valid_o;
        o_inst   = inst_o;
        o_iaddr  = inst_addr_o;
        o_gnt    = o_req && mem_gnt_i;
        o_rvalid = mem_rvalid_i;
        o_pop    = o_valid && inst_ready_i && !redirect_i && !rst_i;
        if (rst_i) begin
            mq.delete();
        end else begin
            if (mem_rvalid_i) void'(mq.pop_front());
            if (o_gnt) begin
                r.addr = o_addr;
                r.due  = cyc + $urandom_range(lat_min, lat_max);
                mq.push_back(r);
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        redirect_i = 1'b0;
        inst_ready_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        exp_pc = RESET_PC;
        exp_fetch = RESET_PC;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        n_total++;
        if (o_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", o_req);
        else n_pass++;
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid);
        else n_pass++;
        n_total++;
        if ({o_inst, o_iaddr} !== 64'h0) $display("FAIL reset_data: got %h/%h expected 0/0", o_inst, o_iaddr);
        else n_pass++;
    endtask

    task automatic test_sequential();
        int first_gnt = -1;
        int first_val = -1;
        int ndel = 0;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; inst_ready_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (o_gnt) begin
                n_total++;
                if (o_addr !== exp_fetch) $display("FAIL seq_addr: got %h expected %h", o_addr, exp_fetch);
                else n_pass++;
                exp_fetch += 4;
                if (first_gnt < 0) first_gnt = i;
            end
            if (o_valid && first_val < 0) first_val = i;
            if (o_pop) begin
                n_total++;
                if (o_iaddr !== exp_pc || o_inst !== memf(exp_pc))
                    $display("FAIL seq_inst: got %h/%h expected %h/%h", o_iaddr, o_inst, exp_pc, memf(exp_pc));
                else n_pass++;
                exp_pc += 4;
                ndel++;
            end
        end
        n_total++;
        if (first_gnt !== 0) $display("FAIL seq_first_gnt: got cycle %0d expected 0", first_gnt);
        else n_pass++;
        n_total++;
        if (first_val - first_gnt !== 2) $display("FAIL seq_latency: got %0d expected 2", first_val - first_gnt);
        else n_pass++;
        n_total++;
        if (ndel < 10) $display("FAIL seq_throughput: got %0d expected >=10", ndel);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int ngr = 0;
        int resume_addr = -1;
        int ndel = 0;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; inst_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_gnt) begin
                ngr++;
                exp_fetch += 4;
            end
        end
        n_total++;
        if (ngr !== DEPTH) $display("FAIL bp_grants: got %0d expected %0d", ngr, DEPTH);
        else n_pass++;
        n_total++;
        if (o_req !== 1'b0 || o_valid !== 1'b1) $display("FAIL bp_stall: got req=%b valid=%b expected 0/1", o_req, o_valid);
        else n_pass++;
        inst_ready_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (o_gnt) begin
                if (resume_addr < 0) resume_addr = int'(o_addr);
                n_total++;
                if (o_addr !== exp_fetch) $display("FAIL bp_addr: got %h expected %h", o_addr, exp_fetch);
                else n_pass++;
                exp_fetch += 4;
            end
            if (o_pop) begin
                n_total++;
                if (o_iaddr !== exp_pc || o_inst !== memf(exp_pc))
                    $display("FAIL bp_inst: got %h/%h expected %h/%h", o_iaddr, o_inst, exp_pc, memf(exp_pc));
                else n_pass++;
                exp_pc += 4;
                ndel++;
            end
        end
        n_total++;
        if (resume_addr !== 32'h10) $display("FAIL bp_resume: got %h expected 00000010", resume_addr);
        else n_pass++;
        n_total++;
        if (ndel < 6) $display("FAIL bp_drain: got %0d expected >=6", ndel);
        else n_pass++;
    endtask

    task automatic test_redirect();
        int first_del = -1;
        do_reset();
        gnt_pct = 0; redirect_i = 1'b1; redirect_pc_i = 32'h20;
        step();
        redirect_i = 1'b0;
        exp_pc = 32'h20; exp_fetch = 32'h20;
        gnt_pct = 100; lat_min = 6; lat_max = 6; inst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (o_gnt) begin
                n_total++;
                if (o_addr !== exp_fetch) $display("FAIL redir_pre_addr: got %h expected %h", o_addr, exp_fetch);
                else n_pass++;
                exp_fetch += 4;
            end
        end
        n_total++;
        if (o_req !== 1'b0 || mq.size() != 2) $display("FAIL redir_outstanding: got req=%b inflight=%0d expected 0/2", o_req, mq.size());
        else n_pass++;
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        n_total++;
        if (o_req !== 1'b0) $display("FAIL redir_no_req: got %b expected 0", o_req);
        else n_pass++;
        exp_pc = 32'h100; exp_fetch = 32'h100;
        for (int i = 0; i < 28; i++) begin
            step();
            if (o_gnt) exp_fetch += 4;
            if (o_pop) begin
                if (first_del < 0) first_del = int'(o_iaddr);
                n_total++;
                if (o_iaddr !== exp_pc || o_inst !== memf(exp_pc))
                    $display("FAIL redir_inst: got %h/%h expected %h/%h", o_iaddr, o_inst, exp_pc, memf(exp_pc));
                else n_pass++;
                exp_pc += 4;
            end
        end
        n_total++;
        if (first_del !== 32'h100) $display("FAIL redir_first: got %h expected 00000100", first_del);
        else n_pass++;
    endtask

    task automatic test_redirect_pop_rvalid();
        bit found = 0;
        int first_del = -1;
        do_reset();
        gnt_pct = 100; lat_min = 2; lat_max = 2; inst_ready_i = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (inst_valid_o && mq.size() >= 2 && mq[0].due <= cyc) begin
                found = 1;
                inst_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h203;
            end
            step();
        end
        redirect_i = 1'b0;
        n_total++;
        if (!found || o_rvalid !== 1'b1 || o_valid !== 1'b1 || o_req !== 1'b0)
            $display("FAIL rpr_setup: got found=%0d rvalid=%b valid=%b req=%b expected 1/1/1/0", found, o_rvalid, o_valid, o_req);
        else n_pass++;
        exp_pc = 32'h200; exp_fetch = 32'h200;
        step();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL rpr_flush: got valid=%b expected 0", o_valid);
        else n_pass++;
        n_total++;
        if (o_req !== 1'b1 || o_addr !== 32'h200) $display("FAIL rpr_fetch: got req=%b addr=%h expected 1/00000200", o_req, o_addr);
        else n_pass++;
        if (o_gnt) exp_fetch += 4;
        for (int i = 0; i < 16; i++) begin
            step();
            if (o_gnt) exp_fetch += 4;
            if (o_pop) begin
                if (first_del < 0) first_del = int'(o_iaddr);
                n_total++;
                if (o_iaddr !== exp_pc || o_inst !== memf(exp_pc))
                    $display("FAIL rpr_inst: got %h/%h expected %h/%h", o_iaddr, o_inst, exp_pc, memf(exp_pc));
                else n_pass++;
                exp_pc += 4;
            end
        end
        n_total++;
        if (first_del !== 32'h200) $display("FAIL rpr_first: got %h expected 00000200", first_del);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first_del = -1;
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 3; inst_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        step();
        n_total++;
        if (o_req !== 1'b0) $display("FAIL b2b_req1: got %b expected 0", o_req);
        else n_pass++;
        redirect_pc_i = 32'h80;
        step();
        redirect_i = 1'b0;
        n_total++;
        if (o_req !== 1'b0) $display("FAIL b2b_req2: got %b expected 0", o_req);
        else n_pass++;
        exp_pc = 32'h80; exp_fetch = 32'h80;
        for (int i = 0; i < 30; i++) begin
            step();
            if (o_gnt) begin
                n_total++;
                if (o_addr !== exp_fetch) $display("FAIL b2b_addr: got %h expected %h", o_addr, exp_fetch);
                else n_pass++;
                exp_fetch += 4;
            end
            if (o_pop) begin
                if (first_del < 0) first_del = int'(o_iaddr);
                n_total++;
                if (o_iaddr !== exp_pc || o_inst !== memf(exp_pc))
                    $display("FAIL b2b_inst: got %h/%h expected %h/%h", o_iaddr, o_inst, exp_pc, memf(exp_pc));
                else n_pass++;
                exp_pc += 4;
            end
        end
        n_total++;
        if (first_del !== 32'h80) $display("FAIL b2b_first: got %h expected 00000080", first_del);
        else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] ga [3];
        int ng = 0;
        do_reset();
        gnt_pct = 0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        step();
        redirect_i = 1'b0;
        exp_pc = 32'hFFFF_FFF8;
        gnt_pct = 100; lat_min = 1; lat_max = 1; inst_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_gnt && ng < 3) begin
                ga[ng] = o_addr;
                ng++;
            end
            if (o_pop) begin
                n_total++;
                if (o_iaddr !== exp_pc || o_inst !== memf(exp_pc))
                    $display("FAIL wrap_inst: got %h/%h expected %h/%h", o_iaddr, o_inst, exp_pc, memf(exp_pc));
                else n_pass++;
                exp_pc += 4;
            end
        end
        n_total++;
        if (ng != 3 || ga[0] !== 32'hFFFF_FFF8 || ga[1] !== 32'hFFFF_FFFC || ga[2] !== 32'h0)
            $display("FAIL wrap_addr: got %h %h %h expected fffffff8 fffffffc 00000000", ga[0], ga[1], ga[2]);
        else n_pass++;
        rst_i = 1'b1;
        step();
        n_total++;
        if (o_req !== 1'b0) $display("FAIL rst_mid_req: got %b expected 0", o_req);
        else n_pass++;
        rst_i = 1'b0;
        step();
        n_total++;
        if (o_valid !== 1'b0 || o_inst !== 32'h0 || o_iaddr !== 32'h0)
            $display("FAIL rst_mid_out: got %b %h %h expected 0 0 0", o_valid, o_inst, o_iaddr);
        else n_pass++;
        n_total++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) $display("FAIL rst_mid_fetch: got req=%b addr=%h expected 1/%h", o_req, o_addr, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        bit          redir;
        do_reset();
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            inst_ready_i = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 99) < 4);
            redirect_i = redir;
            tgt = $urandom;
            redirect_pc_i = tgt;
            step();
            if (redir) begin
                n_total++;
                if (o_req !== 1'b0) $display("FAIL rnd_redir_req: got %b expected 0", o_req);
                else n_pass++;
                exp_pc = {tgt[31:2], 2'b00};
                exp_fetch = {tgt[31:2], 2'b00};
            end else begin
                if (o_gnt) begin
                    n_total++;
                    if (o_addr !== exp_fetch) $display("FAIL rnd_addr: got %h expected %h", o_addr, exp_fetch);
                    else n_pass++;
                    exp_fetch += 4;
                end
                if (o_pop) begin
                    n_total++;
                    if (o_iaddr !== exp_pc || o_inst !== memf(exp_pc))
                        $display("FAIL rnd_inst: got %h/%h expected %h/%h", o_iaddr, o_inst, exp_pc, memf(exp_pc));
                    else n_pass++;
                    exp_pc += 4;
                end
            end
            if (mq.size() > MAX_OUT) begin
                n_total++;
                $display("FAIL rnd_outstanding: got %0d expected <=%0d", mq.size(), MAX_OUT);
            end
        end
        redirect_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_pop_rvalid();
        test_back_to_back();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
